key_schedule_stream: RTL and testbench

- Parametrised streaming AES key-expansion controller; successor to `key_expansion_control`.
- Accepts a cipher key serially over a valid/ready bus of configurable width. Supports AES-128/192/256, selected per key.
- Emits the round keys 0..Nr in order as 128-bit words on a valid/ready output with backpressure.
- Sits between the key-load interface and the round datapath.

---
 rtl/aes_ks_pkg.sv | 66 ++++++
 rtl/key_schedule_stream_if.sv | 25 ++
 rtl/aes_sub_word.sv | 39 +++
 rtl/key_schedule_stream.sv | 147 ++++++++++++++
 tb/tb_key_schedule_stream.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the streaming AES key-schedule controller:
// key-length encodings, per-mode word counts, Rcon helpers and the FSM states.
package aes_ks_pkg;

  typedef enum logic [1:0] {
    KL_128     = 2'b00,
    KL_192     = 2'b01,
    KL_256     = 2'b10,
    KL_128_ALT = 2'b11
  } key_len_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  localparam int NW_128 = 4 * (NR_128 + 1);
  localparam int NW_192 = 4 * (NR_192 + 1);
  localparam int NW_256 = 4 * (NR_256 + 1);

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND,
    DRAIN
  } ks_state_e;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } rk_t;

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'(NK_192);
      KL_256:  return 4'(NK_256);
      default: return 4'(NK_128);
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'(NR_192);
      KL_256:  return 4'(NR_256);
      default: return 4'(NR_128);
    endcase
  endfunction

  function automatic logic [5:0] nw_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 6'(NW_192);
      KL_256:  return 6'(NW_256);
      default: return 6'(NW_128);
    endcase
  endfunction

  // GF(2^8) doubling with the AES polynomial; 0x80 -> 0x1B
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_schedule_stream_if.sv
// Key-load and round-key buses of key_schedule_stream. The key schedule
// itself is the slave; the key source / round datapath side is the master.
interface key_schedule_stream_if #(
  parameter int IN_W = 8
);
  logic [1:0]      key_len;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    rk_data;
  logic [3:0]      rk_round;
  logic            rk_last;
  logic            rk_valid;
  logic            rk_ready;

  modport master (
    output key_len, in_data, in_valid, rk_ready,
    input  in_ready, rk_data, rk_round, rk_last, rk_valid
  );

  modport slave (
    input  key_len, in_data, in_valid, rk_ready,
    output in_ready, rk_data, rk_round, rk_last, rk_valid
  );
endinterface

// File: rtl/aes_sub_word.sv
// Combinational AES SubWord: one S-box lookup per byte lane.
module aes_sub_word #(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0][7:0] din,
  output logic [NUM_LANES-1:0][7:0] dout
);

  // Row r holds S(r*16 + 0) .. S(r*16 + 15), most significant byte first
  localparam logic [0:15][127:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX[b[7:4]];
    return row[{4'd15 - b[3:0], 3'b000} +: 8];
  endfunction

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign dout[g] = sbox(din[g]);
  end

endmodule

// File: rtl/key_schedule_stream.sv
// Streaming AES-128/192/256 key expansion: serial key load, one schedule word
// per cycle, round keys out on a valid/ready bus. KEY_SCHED_ZEROIZE_EN wipes key material after the last round key.
module key_schedule_stream
  import aes_ks_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  key_schedule_stream_if.slave bus
);

  localparam int BPW = 32 / IN_W;

  ks_state_e         state, state_nxt;
  logic [1:0]        kl_q;
  logic [5:0]        beat_cnt;
  logic [5:0]        wi;
  logic [2:0]        kpos;
  logic [7:0]        rcon;
  logic [7:0][31:0]  win;
  logic [2:0][31:0]  acc;
  rk_t               rk_q;
  logic              rk_vld;

  logic [3:0]   nk;
  logic [5:0]   nw, beats_tot, beats_first;
  logic [2:0]   old_idx;
  logic         in_rdy, beat_acc, produce, grp_end, last_word, out_free;
  logic [31:0]  w_prev, w_old, sw_in, sw_out, w_new;
  logic [255:0] win_shift;

  assign nk          = nk_of(kl_q);
  assign nw          = nw_of(kl_q);
  assign old_idx     = 3'(nk - 4'd1);
  assign beats_tot   = 6'(int'(nk) * BPW);
  assign beats_first = 6'(int'(nk_of(bus.key_len)) * BPW);

  assign beat_acc  = bus.in_valid && in_rdy;
  assign out_free  = !rk_vld || bus.rk_ready;
  assign grp_end   = &wi[1:0];
  assign last_word = (wi == nw - 6'd1);

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    produce   = 1'b0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = (beats_first == 6'd1) ? EXPAND : LOAD;
      end
      LOAD: begin
        in_rdy = 1'b1;
        if (bus.in_valid && beat_cnt == beats_tot - 6'd1) state_nxt = EXPAND;
      end
      EXPAND: begin
        // Only the group-completing word waits for the output register
        produce = !grp_end || out_free;
        if (produce && last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (rk_vld && bus.rk_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // win[0] is w[i-1], win[Nk-1] is w[i-Nk]; during the first Nk cycles the
  // loaded key simply rotates through, so both phases share one datapath.
  assign w_prev    = win[0];
  assign w_old     = win[old_idx];
  assign sw_in     = (kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign win_shift = {win} << IN_W;

  aes_sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_comb begin
    if ({2'b00, nk} > wi)                  w_new = w_old;
    else if (kpos == 3'd0)                 w_new = w_old ^ sw_out ^ {rcon, 24'h0};
    else if (nk == 4'd8 && kpos == 3'd4)   w_new = w_old ^ sw_out;
    else                                   w_new = w_old ^ w_prev;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kl_q     <= '0;
      beat_cnt <= '0;
      wi       <= '0;
      kpos     <= '0;
      rcon     <= RCON_INIT;
      win      <= '0;
      acc      <= '0;
      rk_q     <= '0;
      rk_vld   <= 1'b0;
    end else begin
      if (beat_acc) begin
        win      <= win_shift | 256'(bus.in_data);
        beat_cnt <= beat_cnt + 6'd1;
        if (state == IDLE) begin
          kl_q     <= bus.key_len;
          beat_cnt <= 6'd1;
          wi       <= '0;
          kpos     <= '0;
          rcon     <= RCON_INIT;
        end
      end
      if (produce) begin
        win  <= {win[6:0], w_new};
        acc  <= {acc[1:0], w_new};
        wi   <= wi + 6'd1;
        kpos <= (kpos == old_idx) ? 3'd0 : kpos + 3'd1;
        if ({2'b00, nk} <= wi && kpos == 3'd0) rcon <= xtime(rcon);
      end
      if (produce && grp_end) begin
        rk_q   <= '{data: {acc, w_new}, round: wi[5:2], last: last_word};
        rk_vld <= 1'b1;
      end else if (rk_vld && bus.rk_ready) begin
        rk_vld <= 1'b0;
        if (rk_q.last) begin
          rk_q.last  <= 1'b0;
          rk_q.round <= '0;
`ifdef KEY_SCHED_ZEROIZE_EN
          rk_q.data  <= '0;
          win        <= '0;
          acc        <= '0;
`endif
        end
      end
    end
  end

  assign bus.in_ready = in_rdy;
  assign bus.rk_data  = rk_q.data;
  assign bus.rk_round = rk_q.round;
  assign bus.rk_last  = rk_q.last;
  assign bus.rk_valid = rk_vld;

endmodule

// File: tb/tb_key_schedule_stream.sv
// Directed bench for key_schedule_stream: FIPS-197 key vectors on an 8-bit and
// a 32-bit instance, latency/throughput, backpressure, async reset, end-of-key clearing.
module tb_key_schedule_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_schedule_stream_if #(.IN_W(8))  b8 ();
  key_schedule_stream_if #(.IN_W(32)) b32 ();

  key_schedule_stream #(.IN_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
  key_schedule_stream #(.IN_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

  logic        sel, in_valid, rk_ready;
  logic [1:0]  key_len;
  logic [31:0] beat;

  assign b8.key_len   = key_len;
  assign b8.in_data   = beat[7:0];
  assign b8.in_valid  = in_valid & ~sel;
  assign b8.rk_ready  = rk_ready;
  assign b32.key_len  = key_len;
  assign b32.in_data  = beat;
  assign b32.in_valid = in_valid & sel;
  assign b32.rk_ready = rk_ready;

  logic         o_valid, o_last, o_in_ready;
  logic [3:0]   o_round;
  logic [127:0] o_data;
  assign o_valid    = sel ? b32.rk_valid : b8.rk_valid;
  assign o_last     = sel ? b32.rk_last  : b8.rk_last;
  assign o_in_ready = sel ? b32.in_ready : b8.in_ready;
  assign o_round    = sel ? b32.rk_round : b8.rk_round;
  assign o_data     = sel ? b32.rk_data  : b8.rk_data;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] RK128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int           n_vec = 0;
  int           n_bad = 0;
  logic [127:0] got     [16];
  logic [3:0]   got_rnd [16];
  logic         got_lst [16];
  int           n_hs, t_first, t_last;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Beats are driven MSB-first from a left-aligned 256-bit key
  task automatic load_key(input logic [255:0] key, input logic [1:0] kl, input int nbits);
    int w, nb;
    w  = sel ? 32 : 8;
    nb = nbits / w;
    key_len = kl;
    for (int b = 0; b < nb; b++) begin
      beat     = sel ? key[255 - b*32 -: 32] : {24'h0, key[255 - b*8 -: 8]};
      in_valid = 1'b1;
      if (b == 0 || b == nb - 1) chk("in_ready_load", 128'(o_in_ready), 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Entered just after the last-beat edge (edge 0); cycle numbers count edges.
  task automatic run_rounds(input int pct);
    logic         stall, pl;
    logic [127:0] pd;
    logic [3:0]   pr;
    bit           done;
    n_hs = 0; t_first = -1; t_last = -1;
    stall = 1'b0; pd = '0; pr = '0; pl = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (o_valid && t_first < 0) t_first = cyc;
      if (o_valid && o_last && t_last < 0) t_last = cyc;
      if (stall) begin
        chk("stall_data", o_data, pd);
        chk("stall_tag", 128'({o_valid, o_round, o_last}), 128'({1'b1, pr, pl}));
      end
      rk_ready = (int'($urandom_range(99)) < pct);
      if (o_valid && rk_ready) begin
        if (n_hs < 16) begin
          got[n_hs]     = o_data;
          got_rnd[n_hs] = o_round;
          got_lst[n_hs] = o_last;
        end
        n_hs++;
        done = o_last;
      end
      stall = o_valid && !rk_ready;
      pd = o_data; pr = o_round; pl = o_last;
      @(posedge clk); #1;
    end
    chk("rounds_done", 128'(done), 128'd1);
    rk_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_idle;
    bit found;
    rst = 1'b0; sel = 1'b0; in_valid = 1'b0; rk_ready = 1'b0; key_len = 2'b00; beat = '0;
    #1;
    chk("rst_ctrl", 128'({o_valid, o_last, o_round}), 128'd0);
    chk("rst_data", o_data, 128'd0);
    #20;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_idle", 128'(o_in_ready), 128'd1);

`ifdef KEY_SCHED_ZEROIZE_EN
    exp_idle = '0;
`else
    exp_idle = RK128[10];
`endif

    // AES-128, 8-bit beats, consumer always ready
    load_key(K128, 2'b00, 128);
    run_rounds(100);
    chk("a128_first_lat", 128'(t_first), 128'd4);
    chk("a128_last_lat", 128'(t_last), 128'd44);
    chk("a128_hs", 128'(n_hs), 128'd11);
    chk("a128_rk0", got[0], RK128[0]);
    chk("a128_rk1", got[1], RK128[1]);
    chk("a128_rk10", got[10], RK128[10]);
    chk("a128_tag10", 128'({got_rnd[10], got_lst[10]}), 128'({4'd10, 1'b1}));
    chk("a128_tag9", 128'({got_rnd[9], got_lst[9]}), 128'({4'd9, 1'b0}));
    chk("idle_ctrl", 128'({o_valid, o_last, o_round, o_in_ready}), 128'd1);
    chk("idle_data", o_data, exp_idle);

    // AES-128 again under random backpressure
    load_key(K128, 2'b00, 128);
    run_rounds(30);
    chk("bp_hs", 128'(n_hs), 128'd11);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("bp_rk%0d", k), got[k], RK128[k]);
      chk($sformatf("bp_round%0d", k), 128'(got_rnd[k]), 128'(k));
    end

    // AES-192, 32-bit beats
    sel = 1'b1;
    load_key(K192, 2'b01, 192);
    run_rounds(100);
    chk("a192_hs", 128'(n_hs), 128'd13);
    chk("a192_last_lat", 128'(t_last), 128'd52);
    chk("a192_rk0", got[0], K192[255:128]);
    chk("a192_rk1", got[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("a192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("a192_last12", 128'({got_rnd[12], got_lst[12]}), 128'({4'd12, 1'b1}));

    // AES-256, 32-bit beats
    load_key(K256, 2'b10, 256);
    run_rounds(100);
    chk("a256_hs", 128'(n_hs), 128'd15);
    chk("a256_last_lat", 128'(t_last), 128'd60);
    chk("a256_rk0", got[0], K256[255:128]);
    chk("a256_rk1", got[1], K256[127:0]);
    chk("a256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("a256_last14", 128'({got_rnd[14], got_lst[14]}), 128'({4'd14, 1'b1}));

    // key_len 11 selects AES-128
    load_key(K128, 2'b11, 128);
    run_rounds(100);
    chk("kl11_hs", 128'(n_hs), 128'd11);
    chk("kl11_rk10", got[10], RK128[10]);

    // Async reset while round 3 is pending
    sel = 1'b0;
    load_key(K128, 2'b00, 128);
    rk_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk); #1;
      if (o_valid && o_round == 4'd3) begin
        found = 1'b1;
        rk_ready = 1'b0;
      end
    end
    chk("r3_pending", 128'({found, o_valid, o_round}), 128'({1'b1, 1'b1, 4'd3}));
    in_valid = 1'b1; beat = 32'hff;
    chk("expand_no_ready", 128'(o_in_ready), 128'd0);
    @(posedge clk); #1;
    chk("expand_no_ready2", 128'(o_in_ready), 128'd0);
    chk("r3_held", o_data, RK128[3]);
    #2;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrst_ctrl", 128'({o_valid, o_last, o_round}), 128'd0);
    chk("midrst_data", o_data, 128'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst_ready", 128'(o_in_ready), 128'd1);
    load_key(K128, 2'b00, 128);
    run_rounds(100);
    chk("postrst_hs", 128'(n_hs), 128'd11);
    chk("postrst_rk3", got[3], RK128[3]);
    chk("postrst_rk10", got[10], RK128[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
